// File: rtl/snn_pkg.sv
// snn_pkg: shared definitions for the spiking-network inference controller.
//   - Default sizes for the classifier (class count, score width, window width).
//   - Class index width derived from the default class count.
//   - Controller state encoding.
package snn_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_WIDTH_P     = 8;
  localparam int DEF_WINDOW_W    = 8;
  localparam int DEF_IDX_W       = $clog2(DEF_NUM_CLASSES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/snn_argmax_seq.sv
// snn_argmax_seq: serial argmax over the class accumulators.
// Walks a read index across all classes, one per step, and keeps the
// strictly-largest score seen so far together with its index. Because the
// compare is strict, ties keep the lowest index.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   start_i          restart the scan: index, best score and best index to 0
//   step_i           compare score_i against the current best, advance index
//   score_i          accumulator value selected by sel_o
//   sel_o            accumulator read select (registered)
//   done_o           the current index is the last class
//   best_nxt_o       best score including the current compare
//   best_idx_nxt_o   best index including the current compare
module snn_argmax_seq
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int WIDTH_P     = DEF_WIDTH_P,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH_P-1:0] score_i,
  output logic [IDX_W-1:0]   sel_o,
  output logic               done_o,
  output logic [WIDTH_P-1:0] best_nxt_o,
  output logic [IDX_W-1:0]   best_idx_nxt_o
);

  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH_P-1:0] r_best;
  logic [IDX_W-1:0]   r_best_idx;

  assign sel_o  = r_idx;
  assign done_o = (r_idx == IDX_W'(NUM_CLASSES - 1));

  // Strict-greater compare of the selected score against the running best.
  always_comb begin
    best_nxt_o     = r_best;
    best_idx_nxt_o = r_best_idx;
    if (score_i > r_best) begin
      best_nxt_o     = score_i;
      best_idx_nxt_o = r_idx;
    end else begin
      best_nxt_o     = r_best;
      best_idx_nxt_o = r_best_idx;
    end
  end

  // Scan index and best-so-far registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= {IDX_W{1'b0}};
      r_best     <= {WIDTH_P{1'b0}};
      r_best_idx <= {IDX_W{1'b0}};
    end else if (start_i) begin
      r_idx      <= {IDX_W{1'b0}};
      r_best     <= {WIDTH_P{1'b0}};
      r_best_idx <= {IDX_W{1'b0}};
    end else if (step_i) begin
      r_best     <= best_nxt_o;
      r_best_idx <= best_idx_nxt_o;
      // Wrap to 0 after the last class so the select rests at 0 between passes.
      r_idx      <= done_o ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));
    end else begin
      r_idx      <= r_idx;
      r_best     <= r_best;
      r_best_idx <= r_best_idx;
    end
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl: sequences one classification pass through the spiking
// network. It accepts a sample, clears the network, drives the sample for the
// integration window, serially scans the class accumulators for the argmax,
// and presents the winner until the consumer takes it. One sample in flight.
// Optional feature macro: SNN_CTRL_EARLY_EXIT_EN -- when defined, sat_i high
// during RUN ends integration immediately; otherwise sat_i is ignored.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   cfg_window_i                   integration cycles (0 acts as 1), taken at accept
//   in_valid_i/in_ready_o/in_data_i  sample handshake and value
//   sat_i                          network saturation flag
//   net_data_o/net_clear_o/net_run_o network drive, clear and integrate enable
//   score_sel_o/score_i            accumulator read select and value
//   res_valid_o/res_ready_i        result handshake
//   res_class_o/res_score_o        winning class and its score
//   busy_o                         controller is not idle
module snn_inference_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int WIDTH_P     = DEF_WIDTH_P,
  parameter int WINDOW_W    = DEF_WINDOW_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WINDOW_W-1:0] cfg_window_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [7:0]          in_data_i,
  input  logic                sat_i,
  output logic [7:0]          net_data_o,
  output logic                net_clear_o,
  output logic                net_run_o,
  output logic [IDX_W-1:0]    score_sel_o,
  input  logic [WIDTH_P-1:0]  score_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [IDX_W-1:0]    res_class_o,
  output logic [WIDTH_P-1:0]  res_score_o,
  output logic                busy_o
);

  state_e              r_state;
  logic [7:0]          r_data;
  logic [WINDOW_W-1:0] r_win;
  logic [WINDOW_W-1:0] r_cnt;
  logic [7:0]          r_net_data;
  logic                r_net_clear;
  logic                r_net_run;
  logic                r_res_valid;
  logic [IDX_W-1:0]    r_res_class;
  logic [WIDTH_P-1:0]  r_res_score;
  logic                r_busy;

  logic                w_accept;
  logic                w_run_end;
  logic                w_start;
  logic                w_step;
  logic                w_scan_last;
  logic [WIDTH_P-1:0]  w_best_nxt;
  logic [IDX_W-1:0]    w_best_idx_nxt;

  assign in_ready_o = (r_state == ST_IDLE);
  assign w_accept   = in_valid_i & in_ready_o;

`ifdef SNN_CTRL_EARLY_EXIT_EN
  assign w_run_end = (r_cnt == {WINDOW_W{1'b0}}) | sat_i;
`else
  logic w_unused_sat;
  assign w_unused_sat = sat_i;
  assign w_run_end    = (r_cnt == {WINDOW_W{1'b0}});
`endif

  // The argmax restarts exactly on the RUN-to-SCAN transition.
  assign w_start = (r_state == ST_RUN) & w_run_end;
  assign w_step  = (r_state == ST_SCAN);

  snn_argmax_seq #(
    .NUM_CLASSES (NUM_CLASSES),
    .WIDTH_P     (WIDTH_P),
    .IDX_W       (IDX_W)
  ) u_argmax (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (w_start),
    .step_i         (w_step),
    .score_i        (score_i),
    .sel_o          (score_sel_o),
    .done_o         (w_scan_last),
    .best_nxt_o     (w_best_nxt),
    .best_idx_nxt_o (w_best_idx_nxt)
  );

  assign net_data_o  = r_net_data;
  assign net_clear_o = r_net_clear;
  assign net_run_o   = r_net_run;
  assign res_valid_o = r_res_valid;
  assign res_class_o = r_res_class;
  assign res_score_o = r_res_score;
  assign busy_o      = r_busy;

  // Controller FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_data      <= 8'd0;
      r_win       <= {WINDOW_W{1'b0}};
      r_cnt       <= {WINDOW_W{1'b0}};
      r_net_data  <= 8'd0;
      r_net_clear <= 1'b0;
      r_net_run   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_class <= {IDX_W{1'b0}};
      r_res_score <= {WIDTH_P{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data      <= in_data_i;
            r_win       <= (cfg_window_i == {WINDOW_W{1'b0}}) ? WINDOW_W'(1) : cfg_window_i;
            r_net_clear <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_CLEAR;
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_cnt       <= r_win - WINDOW_W'(1);
          r_net_clear <= 1'b0;
          r_net_run   <= 1'b1;
          r_net_data  <= r_data;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          if (w_run_end) begin
            r_net_run  <= 1'b0;
            r_net_data <= 8'd0;
            r_state    <= ST_SCAN;
          end else begin
            r_cnt      <= r_cnt - WINDOW_W'(1);
          end
        end
        ST_SCAN: begin
          // The final compare lands directly in the result registers.
          if (w_scan_last) begin
            r_res_valid <= 1'b1;
            r_res_class <= w_best_idx_nxt;
            r_res_score <= w_best_nxt;
            r_state     <= ST_DONE;
          end else begin
            r_state     <= ST_SCAN;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_res_class <= {IDX_W{1'b0}};
            r_res_score <= {WIDTH_P{1'b0}};
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_net_data  <= 8'd0;
          r_net_clear <= 1'b0;
          r_net_run   <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// tb_snn_inference_ctrl: directed bench for snn_inference_ctrl. The accumulator
// bank is modelled as a table indexed by score_sel_o. Cycle n is the cycle
// after clock edge n, with the accepting edge numbered 1 (CLEAR is cycle 1).
module tb_snn_inference_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] cfg_window_i = 8'd0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_data_i = 8'd0;
  logic       sat_i = 1'b0;
  logic [7:0] net_data_o;
  logic       net_clear_o;
  logic       net_run_o;
  logic [3:0] score_sel_o;
  logic [7:0] score_i;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic [3:0] res_class_o;
  logic [7:0] res_score_o;
  logic       busy_o;

  logic [7:0] scores [10];

  int n_checks = 0;
  int n_pass   = 0;

  int m_first_valid, m_clear_cnt, m_clear_first, m_run_cnt, m_run_first;
  int m_data_bad, m_busy_bad;

  snn_inference_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_window_i (cfg_window_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .sat_i        (sat_i),
    .net_data_o   (net_data_o),
    .net_clear_o  (net_clear_o),
    .net_run_o    (net_run_o),
    .score_sel_o  (score_sel_o),
    .score_i      (score_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_class_o  (res_class_o),
    .res_score_o  (res_score_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Accumulator bank model: combinational read by select.
  always_comb begin
    score_i = 8'd0;
    if (score_sel_o < 4'd10) begin
      score_i = scores[score_sel_o];
    end else begin
      score_i = 8'd0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present a sample for one handshake; the edge it lands on is edge 1.
  task automatic do_accept(input logic [7:0] d, input logic [7:0] w);
    @(negedge clk_i);
    in_valid_i   = 1'b1;
    in_data_i    = d;
    cfg_window_i = w;
    @(posedge clk_i);
    #1;
    in_valid_i   = 1'b0;
    in_data_i    = ~d;
    cfg_window_i = 8'd99;
  endtask

  // Observe cycles 1.. until res_valid_o, recording per-cycle behaviour.
  task automatic measure(input logic [7:0] exp_data, input int sat_cycle, input int budget);
    m_first_valid = 0; m_clear_cnt = 0; m_clear_first = 0;
    m_run_cnt = 0; m_run_first = 0; m_data_bad = 0; m_busy_bad = 0;
    for (int n = 1; n <= budget; n++) begin
      if (n > 1) begin
        @(posedge clk_i);
        #1;
      end
      if (net_clear_o) begin
        m_clear_cnt++;
        if (m_clear_first == 0) m_clear_first = n;
      end
      if (net_run_o) begin
        m_run_cnt++;
        if (m_run_first == 0) m_run_first = n;
      end
      if (net_data_o != (net_run_o ? exp_data : 8'd0)) m_data_bad++;
      if (!busy_o || in_ready_o) m_busy_bad++;
      if (res_valid_o) begin
        m_first_valid = n;
        break;
      end
      sat_i = (n == sat_cycle);
    end
    sat_i = 1'b0;
  endtask

  task automatic handshake(input string tag);
    @(negedge clk_i);
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    chk({tag, "_idle_ready"}, int'(in_ready_o), 1);
    chk({tag, "_idle_valid"}, int'(res_valid_o), 0);
    chk({tag, "_idle_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) scores[i] = 8'd0;

    // Reset values.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_res_valid", int'(res_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_net_clear", int'(net_clear_o), 0);
    chk("rst_net_run", int'(net_run_o), 0);
    chk("rst_net_data", int'(net_data_o), 0);
    chk("rst_score_sel", int'(score_sel_o), 0);
    chk("rst_res_class", int'(res_class_o), 0);
    chk("rst_res_score", int'(res_score_o), 0);

    // W=4, tie between classes 1 and 2 resolves to 1; latency 4+10+2 = 16.
    scores = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_accept(8'h50, 8'd4);
    measure(8'h50, 0, 100);
    chk("t1_first_valid", m_first_valid, 16);
    chk("t1_clear_cnt", m_clear_cnt, 1);
    chk("t1_clear_cycle", m_clear_first, 1);
    chk("t1_run_cnt", m_run_cnt, 4);
    chk("t1_run_first", m_run_first, 2);
    chk("t1_data_bad", m_data_bad, 0);
    chk("t1_busy_bad", m_busy_bad, 0);
    chk("t1_class", int'(res_class_o), 1);
    chk("t1_score", int'(res_score_o), 9);
    handshake("t1");

    // Window 0 acts as 1: one RUN cycle, so latency 1+10+2 = 13.
    for (int i = 0; i < 10; i++) scores[i] = 8'd0;
    do_accept(8'h0F, 8'd0);
    measure(8'h0F, 0, 100);
    chk("t2_first_valid", m_first_valid, 13);
    chk("t2_run_cnt", m_run_cnt, 1);
    chk("t2_class", int'(res_class_o), 0);
    chk("t2_score", int'(res_score_o), 0);
    handshake("t2");

    // Max 255 at the last index; result held while the consumer stalls.
    scores = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd254, 8'd255};
    do_accept(8'hA1, 8'd2);
    measure(8'hA1, 0, 100);
    chk("t3_first_valid", m_first_valid, 14);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i);
      #1;
      chk("t3_hold_valid", int'(res_valid_o), 1);
      chk("t3_hold_class", int'(res_class_o), 9);
      chk("t3_hold_score", int'(res_score_o), 255);
      chk("t3_hold_in_ready", int'(in_ready_o), 0);
    end

    // Ready and a new sample together in DONE: only the result is taken.
    @(negedge clk_i);
    res_ready_i  = 1'b1;
    in_valid_i   = 1'b1;
    in_data_i    = 8'h33;
    cfg_window_i = 8'd20;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    chk("t3_done_idle_ready", int'(in_ready_o), 1);
    chk("t3_done_not_busy", int'(busy_o), 0);
    chk("t3_done_valid_low", int'(res_valid_o), 0);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    chk("t3_late_accept_busy", int'(busy_o), 1);
    chk("t3_late_accept_clear", int'(net_clear_o), 1);

    // Async reset in the middle of RUN, then an immediate new accept.
    repeat (3) @(posedge clk_i);
    #1;
    chk("t4_in_run", int'(net_run_o), 1);
    chk("t4_run_data", int'(net_data_o), 8'h33);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t4_rst_run", int'(net_run_o), 0);
    chk("t4_rst_data", int'(net_data_o), 0);
    chk("t4_rst_ready", int'(in_ready_o), 1);
    chk("t4_rst_busy", int'(busy_o), 0);
    in_valid_i   = 1'b1;
    in_data_i    = 8'h7E;
    cfg_window_i = 8'd3;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    measure(8'h7E, 0, 100);
    chk("t4_clear_cycle", m_clear_first, 1);
    chk("t4_first_valid", m_first_valid, 15);
    chk("t4_class", int'(res_class_o), 9);
    chk("t4_score", int'(res_score_o), 255);
    handshake("t4");

    // W=200 with sat_i in the third RUN cycle (cycle 4).
    scores = '{8'd0, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0};
    do_accept(8'hC3, 8'd200);
    measure(8'hC3, 4, 400);
`ifdef SNN_CTRL_EARLY_EXIT_EN
    chk("t5_run_cnt", m_run_cnt, 3);
    chk("t5_first_valid", m_first_valid, 15);
`else
    chk("t5_run_cnt", m_run_cnt, 200);
    chk("t5_first_valid", m_first_valid, 212);
`endif
    chk("t5_class", int'(res_class_o), 3);
    chk("t5_score", int'(res_score_o), 7);
    chk("t5_data_bad", m_data_bad, 0);
    handshake("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
